// File: rtl/regfile_pkg.sv
// Shared defaults and address-validity rule for the register file and its scoreboard.
package regfile_pkg;

    localparam int DEFAULT_XLEN  = 32;
    localparam int DEFAULT_NREGS = 32;

    // Register 0 is invalid when hardwired to zero; anything past the last register is invalid too.
    function automatic logic is_valid_addr(input int unsigned addr,
                                           input int unsigned nregs,
                                           input logic        zero_reg);
        return !(zero_reg && (addr == 0)) && (addr < nregs);
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback facing bus of the register file: reads, writeback, issue marking and flush.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = DEFAULT_XLEN,
    parameter int NREGS = DEFAULT_NREGS,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(NREGS + 1);

    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NRD-1:0]           rd_busy;
    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic [XLEN-1:0]          wr_data;
    logic                     issue_en;
    logic [AW-1:0]            issue_addr;
    logic                     flush;
    logic [CW-1:0]            busy_count;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
        input  rd_data, rd_busy, busy_count
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
        output rd_data, rd_busy, busy_count
    );

endinterface

// File: rtl/regfile_busy_table.sv
// Busy-bit scoreboard: issue sets, writeback clears, flush wipes everything and drops a same-cycle issue.
module regfile_busy_table
    import regfile_pkg::*;
#(
    parameter  int NREGS    = DEFAULT_NREGS,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS),
    localparam int CW       = $clog2(NREGS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic             i_issue_en,
    input  logic [AW-1:0]    i_issue_addr,
    input  logic             i_flush,
    output logic [NREGS-1:0] o_busy,
    output logic [CW-1:0]    o_busy_count
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busyNext;
    logic             w_wrValid;
    logic             w_issueValid;

    // Issue is applied after the write clear so a new producer wins a same-cycle collision.
    always_comb begin
        w_wrValid    = i_wr_en && is_valid_addr(32'(i_wr_addr), NREGS, ZERO_REG != 0);
        w_issueValid = i_issue_en && !i_flush &&
                       is_valid_addr(32'(i_issue_addr), NREGS, ZERO_REG != 0);
        w_busyNext   = r_busy;
        for (int i = 0; i < NREGS; i++) begin
            if (w_wrValid && (i_wr_addr == AW'(i)))
                w_busyNext[i] = 1'b0;
            if (w_issueValid && (i_issue_addr == AW'(i)))
                w_busyNext[i] = 1'b1;
        end
        if (i_flush)
            w_busyNext = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_busy <= '0;
        else
            r_busy <= w_busyNext;
    end

    always_comb begin
        o_busy_count = '0;
        for (int i = 0; i < NREGS; i++)
            o_busy_count = o_busy_count + CW'(r_busy[i]);
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with busy scoreboard and optional same-cycle writeback forwarding.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN     = DEFAULT_XLEN,
    parameter  int NREGS    = DEFAULT_NREGS,
    parameter  int NRD      = 2,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);

    logic [XLEN-1:0]          r_regs [NREGS];
    logic [NREGS-1:0]         w_busy;
    logic                     w_wrValid;
    logic [NRD-1:0][XLEN-1:0] w_rdData;
    logic [NRD-1:0]           w_rdBusy;

    assign w_wrValid = bus.wr_en && is_valid_addr(32'(bus.wr_addr), NREGS, ZERO_REG != 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++)
                if (w_wrValid && (bus.wr_addr == AW'(i)))
                    r_regs[i] <= bus.wr_data;
        end
    end

    regfile_busy_table #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_busy (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wr_en      (bus.wr_en),
        .i_wr_addr    (bus.wr_addr),
        .i_issue_en   (bus.issue_en),
        .i_issue_addr (bus.issue_addr),
        .i_flush      (bus.flush),
        .o_busy       (w_busy),
        .o_busy_count (bus.busy_count)
    );

    // Forwarded writeback overrides the stored value and also hides the busy bit it is about to clear.
    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            w_rdData[p] = '0;
            w_rdBusy[p] = 1'b0;
            if (is_valid_addr(32'(bus.rd_addr[p]), NREGS, ZERO_REG != 0)) begin
                for (int i = 0; i < NREGS; i++) begin
                    if (bus.rd_addr[p] == AW'(i)) begin
                        w_rdData[p] = r_regs[i];
                        w_rdBusy[p] = w_busy[i];
                    end
                end
                if ((BYPASS != 0) && w_wrValid && (bus.wr_addr == bus.rd_addr[p])) begin
                    w_rdData[p] = bus.wr_data;
                    w_rdBusy[p] = 1'b0;
                end
            end
        end
    end

    assign bus.rd_data = w_rdData;
    assign bus.rd_busy = w_rdBusy;

endmodule

// File: tb/tb_regfile_sb.sv
// Drives a bypassing and a non-bypassing 24-entry, 4-port instance with identical stimulus against a reference model.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 24;
    localparam int NRD   = 4;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NRD-1:0][AW-1:0] rdAddr;
    logic                   wrEn;
    logic [AW-1:0]          wrAddr;
    logic [XLEN-1:0]        wrData;
    logic                   issueEn;
    logic [AW-1:0]          issueAddr;
    logic                   flush;

    int nCompared   = 0;
    int nMismatched = 0;
    bit checkEn     = 1'b0;

    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) ifA ();
    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) ifB ();

    assign ifA.rd_addr = rdAddr;    assign ifB.rd_addr = rdAddr;
    assign ifA.wr_en = wrEn;        assign ifB.wr_en = wrEn;
    assign ifA.wr_addr = wrAddr;    assign ifB.wr_addr = wrAddr;
    assign ifA.wr_data = wrData;    assign ifB.wr_data = wrData;
    assign ifA.issue_en = issueEn;  assign ifB.issue_en = issueEn;
    assign ifA.issue_addr = issueAddr; assign ifB.issue_addr = issueAddr;
    assign ifA.flush = flush;       assign ifB.flush = flush;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .BYPASS(1)) dutA (
        .clk(clk), .rst_n(rst_n), .bus(ifA)
    );
    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .BYPASS(0)) dutB (
        .clk(clk), .rst_n(rst_n), .bus(ifB)
    );

    // Reference model: architectural state as plain arrays.
    logic [XLEN-1:0] mRegs [NREGS];
    bit              mBusy [NREGS];

    function automatic bit mValid(input int a);
        return (a != 0) && (a < NREGS);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mRegs[i] = '0;
                mBusy[i] = 1'b0;
            end
        end else begin
            if (flush)
                for (int i = 0; i < NREGS; i++) mBusy[i] = 1'b0;
            if (wrEn && mValid(int'(wrAddr))) begin
                mRegs[int'(wrAddr)] = wrData;
                mBusy[int'(wrAddr)] = 1'b0;
            end
            if (issueEn && !flush && mValid(int'(issueAddr)))
                mBusy[int'(issueAddr)] = 1'b1;
        end
    end

    function automatic void mRead(input bit byp, input int a,
                                  output logic [XLEN-1:0] d, output logic b);
        d = '0;
        b = 1'b0;
        if (mValid(a)) begin
            if (byp && wrEn && (int'(wrAddr) == a)) begin
                d = wrData;
            end else begin
                d = mRegs[a];
                b = mBusy[a];
            end
        end
    endfunction

    function automatic int mCount();
        int c = 0;
        for (int i = 0; i < NREGS; i++) c += int'(mBusy[i]);
        return c;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn && rst_n) begin
            logic [XLEN-1:0] d;
            logic            b;
            for (int p = 0; p < NRD; p++) begin
                mRead(1'b1, int'(rdAddr[p]), d, b);
                checkOutput($sformatf("A.rd_data[%0d]", p), ifA.rd_data[p], d);
                checkOutput($sformatf("A.rd_busy[%0d]", p), 32'(ifA.rd_busy[p]), 32'(b));
                mRead(1'b0, int'(rdAddr[p]), d, b);
                checkOutput($sformatf("B.rd_data[%0d]", p), ifB.rd_data[p], d);
                checkOutput($sformatf("B.rd_busy[%0d]", p), 32'(ifB.rd_busy[p]), 32'(b));
            end
            checkOutput("A.busy_count", 32'(ifA.busy_count), 32'(mCount()));
            checkOutput("B.busy_count", 32'(ifB.busy_count), 32'(mCount()));
        end
    end

    task automatic applyStimulus(input bit we, input int wa, input logic [31:0] wd,
                                 input bit ie, input int ia, input bit fl,
                                 input int r0, input int r1, input int r2, input int r3);
        @(posedge clk);
        #1;
        wrEn      = we;
        wrAddr    = AW'(wa);
        wrData    = wd;
        issueEn   = ie;
        issueAddr = AW'(ia);
        flush     = fl;
        rdAddr[0] = AW'(r0);
        rdAddr[1] = AW'(r1);
        rdAddr[2] = AW'(r2);
        rdAddr[3] = AW'(r3);
        @(negedge clk);
    endtask

    initial begin
        rdAddr = '0; wrEn = 0; wrAddr = '0; wrData = '0;
        issueEn = 0; issueAddr = '0; flush = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset count A", 32'(ifA.busy_count), 0);
        checkOutput("reset count B", 32'(ifB.busy_count), 0);
        checkEn = 1'b1;

        applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0, 0, 0);
        checkOutput("wr x5 bypass A", ifA.rd_data[0], 32'hDEADBEEF);
        checkOutput("wr x5 nobypass B", ifB.rd_data[0], 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 5, 0, 0, 0);
        checkOutput("x5 next A", ifA.rd_data[0], 32'hDEADBEEF);
        checkOutput("x5 next B", ifB.rd_data[0], 32'hDEADBEEF);

        applyStimulus(0, 0, 0, 1, 7, 0, 5, 7, 0, 0);
        checkOutput("issue x7 same cycle", 32'(ifA.rd_busy[1]), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 5, 7, 0, 0);
        checkOutput("x7 busy A", 32'(ifA.rd_busy[1]), 1);
        checkOutput("x7 count", 32'(ifA.busy_count), 1);
        applyStimulus(1, 7, 32'h12, 0, 0, 0, 5, 7, 0, 0);
        checkOutput("wb x7 busy A", 32'(ifA.rd_busy[1]), 0);
        checkOutput("wb x7 data A", ifA.rd_data[1], 32'h12);
        checkOutput("wb x7 busy B", 32'(ifB.rd_busy[1]), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 5, 7, 0, 0);
        checkOutput("x7 count after wb", 32'(ifA.busy_count), 0);
        checkOutput("x7 data B", ifB.rd_data[1], 32'h12);

        applyStimulus(1, 9, 32'h99, 1, 9, 0, 5, 7, 9, 0);
        checkOutput("x9 collide bypass", ifA.rd_data[2], 32'h99);
        applyStimulus(0, 0, 0, 1, 4, 0, 5, 7, 9, 0);
        checkOutput("x9 busy", 32'(ifA.rd_busy[2]), 1);
        checkOutput("x9 data B", ifB.rd_data[2], 32'h99);
        applyStimulus(0, 0, 0, 1, 6, 0, 5, 7, 9, 3);
        checkOutput("count x9 x4", 32'(ifA.busy_count), 2);
        applyStimulus(0, 0, 0, 1, 3, 1, 5, 7, 9, 3);
        checkOutput("count before flush", 32'(ifA.busy_count), 3);
        checkOutput("flush cycle x9 busy", 32'(ifA.rd_busy[2]), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 5, 7, 9, 3);
        checkOutput("count after flush", 32'(ifA.busy_count), 0);
        checkOutput("x3 dropped", 32'(ifA.rd_busy[3]), 0);

        applyStimulus(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 30, 0, 0);
        checkOutput("x0 no bypass", ifA.rd_data[0], 32'h0);
        applyStimulus(1, 30, 32'hFFFFFFFF, 1, 30, 0, 0, 30, 0, 0);
        checkOutput("a30 no bypass", ifA.rd_data[1], 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 30, 0, 0);
        checkOutput("x0 data B", ifB.rd_data[0], 32'h0);
        checkOutput("a30 busy B", 32'(ifB.rd_busy[1]), 0);
        checkOutput("invalid count", 32'(ifB.busy_count), 0);

        applyStimulus(0, 0, 0, 1, 8, 0, 5, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 5, 0, 0, 0);
        checkOutput("pre-reset count", 32'(ifA.busy_count), 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async reset data A", ifA.rd_data[0], 32'h0);
        checkOutput("async reset data B", ifB.rd_data[0], 32'h0);
        checkOutput("async reset count", 32'(ifA.busy_count), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        for (int n = 0; n < 400; n++) begin
            int wa, r[NRD];
            wa = $urandom_range(0, 31);
            for (int p = 0; p < NRD; p++)
                r[p] = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
            applyStimulus($urandom_range(0, 1), wa, $urandom,
                          $urandom_range(0, 1), $urandom_range(0, 31),
                          $urandom_range(0, 15) == 0, r[0], r[1], r[2], r[3]);
        end

        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port integer register file with an integrated busy-bit scoreboard and optional write-to-read bypass, successor to the core's fixed 32x32 two-read register file. It sits between decode (reads, issue marking) and writeback (writes, busy clear) of the pipelined core. It lets decode detect RAW hazards on registers whose producer has issued but not yet written back.

## Interface
Parameters:
- XLEN, 32, register width in bits
- NREGS, 32, number of architectural registers (2..64, need not be a power of 2)
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy
- BYPASS, 1, 1 = same-cycle writeback data and busy-clear forwarded to read ports
- AW (localparam), $clog2(NREGS), address width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rd_addr  in  NRD x AW (packed)  read addresses
- rd_data  out  NRD x XLEN  read data, combinational
- rd_busy  out  NRD  1 = addressed register has a pending producer
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback address
- wr_data  in  XLEN  writeback data
- issue_en  in  1  mark destination as pending
- issue_addr  in  AW  destination being issued
- flush  in  1  clear every busy bit (pipeline squash)
- busy_count  out  $clog2(NREGS+1)  number of set busy bits

## Operation
- State: regs[NREGS] of XLEN, busy_q[NREGS].
- Reset (rst_n low, any time, no clock needed): all regs = 0, all busy_q = 0; hence rd_data = 0, rd_busy = 0, busy_count = 0.
- Write: wr_en, valid address -> regs[wr_addr] <= wr_data and busy_q[wr_addr] <= 0 at next edge.
- Issue: issue_en, valid address -> busy_q[issue_addr] <= 1.
- Issue and write to same address in one cycle: data written, busy ends at 1 (new producer wins).
- Flush: all busy_q <= 0; an issue in the same cycle is dropped; a write in the same cycle still updates regs.
- Invalid address: ZERO_REG=1 and address 0, or address >= NREGS. Writes and issues are ignored. Reads return data 0 and busy 0.
- Read, BYPASS=0: rd_data = regs[a], rd_busy = busy_q[a].
- Read, BYPASS=1: if wr_en and wr_addr == a and a is valid, rd_data = wr_data and rd_busy = 0. Otherwise same as BYPASS=0.
- Same-cycle issue and flush never affect rd_busy in that cycle.
- All read ports are independent; any mix of ports may hit the same address.
- busy_count = popcount(busy_q), registered state only (no bypass).

## Timing
- Read latency 0 cycles (combinational from rd_addr, and with BYPASS=1 also from wr_*).
- Write visible on reads: same cycle with BYPASS=1, next cycle with BYPASS=0.
- Issue visible on rd_busy and busy_count the cycle after issue_en.
- Flush takes effect on the edge; busy_count = 0 the following cycle.
- No handshakes; every request is accepted in one cycle.

## Structure
- Package regfile_pkg: default XLEN/NREGS constants, function is_valid_addr(addr, NREGS, ZERO_REG).
- Sub-module regfile_busy_table: owns busy_q and the set/clear/flush priority, and produces busy_count.
- Data array and read muxing stay in regfile_sb.

## Test plan
- Reset: drive writes, then assert rst_n low mid-cycle -> rd_data and busy_count are 0 immediately, before any clock edge.
- Write/read, BYPASS=1: wr x5 = 0xDEADBEEF with rd_addr[0]=5 in the same cycle -> rd_data[0] = 0xDEADBEEF that cycle and the next.
- Same write, BYPASS=0: rd_data[0] = 0 in the write cycle, 0xDEADBEEF the next cycle.
- Scoreboard: issue x7 -> next cycle rd_busy=1, busy_count=1. Then write x7 = 0x12 with BYPASS=1 -> rd_busy=0 in the write cycle, busy_count=0 the next cycle.
- Collisions: issue and write x9 in one cycle -> x9 = data, busy=1. Issue x3 alongside flush with x4, x6 busy -> all busy=0, busy_count=0.
- Invalid addresses: x0 and NREGS=24 address 30. Write 0xFFFF_FFFF and issue to each -> reads return 0, not busy, busy_count unchanged. Random regression also checks all NRD=4 ports against a reference model.
